// File: rtl/bf_pkg.sv
// Shared definitions for the bound flasher: FSM states, lamp geometry,
// kickback points and segment end targets.
package bf_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UP16 = 3'd1,
        DN5  = 3'd2,
        UP11 = 3'd3,
        DN0  = 3'd4,
        UP6  = 3'd5,
        DN0F = 3'd6,
        KB0  = 3'd7
    } bf_state_t;

    localparam int unsigned LAMP_N = 16;

    localparam logic [4:0] KB_LO = 5'd6;
    localparam logic [4:0] KB_HI = 5'd11;

    localparam logic [4:0] TGT_UP16 = 5'd16;
    localparam logic [4:0] TGT_DN5  = 5'd5;
    localparam logic [4:0] TGT_UP11 = 5'd11;
    localparam logic [4:0] TGT_DN0  = 5'd0;
    localparam logic [4:0] TGT_UP6  = 5'd6;

    // Thermometer decode: bit i is lit when i is below the lamp count.
    function automatic logic [LAMP_N-1:0] thermo_decode(input logic [4:0] n);
        logic [LAMP_N-1:0] r;
        r = '0;
        for (int i = 0; i < LAMP_N; i++) begin
            r[i] = (i < int'(n));
        end
        return r;
    endfunction

endpackage

// File: rtl/kickback_match_generator.sv
// Flags a kickback request: flick asserted while the counter sits on one of
// the two kickback points. State qualification is left to the caller.
module kickback_match_generator
    import bf_pkg::*;
(
    input  logic       flick,
    input  logic [4:0] counter,
    output logic       kickback_match
);

    assign kickback_match = flick && ((counter == KB_LO) || (counter == KB_HI));

endmodule

// File: rtl/bound_flasher_ctrl.sv
// Bound flasher controller: a 16-lamp thermometer that sweeps up and down
// through fixed bounds, with flick-triggered kickbacks, stepping once per
// STEP_DIV clocks while active.
module bound_flasher_ctrl
    import bf_pkg::*;
#(
    parameter int STEP_DIV = 1
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flick,
    output logic [LAMP_N-1:0] lamp,
    output logic [4:0]        count,
    output logic              busy
);

    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(STEP_DIV - 1);

    bf_state_t     state;
    logic [PW-1:0] presc;
    logic          tick;
    logic          kickback_match;
    logic          kb_take;

    kickback_match_generator u_kb_match (
        .flick          (flick),
        .counter        (count),
        .kickback_match (kickback_match)
    );

    // Kickback only counts while climbing in UP16, or at the top of UP11.
    assign kb_take = kickback_match &&
                     ((state == UP16) || ((state == UP11) && (count == KB_HI)));

    assign tick = (presc == PRESC_MAX);

    // Prescaler: parked at zero in IDLE, wraps on every step while active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if ((state == IDLE) || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Sequencer: IDLE reacts every clock, all other states move one lamp per tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (flick) begin
                        state <= UP16;
                        count <= 5'd1;
                    end else begin
                        count <= 5'd0;
                    end
                end
                UP16: if (tick) begin
                    if (kb_take) begin
                        state <= KB0;
                        count <= count - 5'd1;
                    end else if (count == TGT_UP16) begin
                        state <= DN5;
                        count <= count - 5'd1;
                    end else begin
                        count <= count + 5'd1;
                    end
                end
                DN5: if (tick) begin
                    if (count == TGT_DN5) begin
                        state <= UP11;
                        count <= count + 5'd1;
                    end else begin
                        count <= count - 5'd1;
                    end
                end
                UP11: if (tick) begin
                    if (count == TGT_UP11) begin
                        state <= kb_take ? DN5 : DN0;
                        count <= count - 5'd1;
                    end else begin
                        count <= count + 5'd1;
                    end
                end
                DN0: if (tick) begin
                    if (count == TGT_DN0) begin
                        state <= UP6;
                        count <= count + 5'd1;
                    end else begin
                        count <= count - 5'd1;
                    end
                end
                UP6: if (tick) begin
                    if (count == TGT_UP6) begin
                        state <= DN0F;
                        count <= count - 5'd1;
                    end else begin
                        count <= count + 5'd1;
                    end
                end
                DN0F: if (tick) begin
                    if (count == TGT_DN0) begin
                        state <= IDLE;
                        count <= 5'd0;
                    end else begin
                        count <= count - 5'd1;
                    end
                end
                KB0: if (tick) begin
                    if (count == TGT_DN0) begin
                        state <= UP16;
                        count <= count + 5'd1;
                    end else begin
                        count <= count - 5'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= 5'd0;
                end
            endcase
        end
    end

    assign lamp = thermo_decode(count);
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_bound_flasher_ctrl.sv
// Self-checking bench: two controllers (STEP_DIV=1 and STEP_DIV=4) driven by
// the same flick/reset, compared each cycle against a segment-table model.
module tb_bound_flasher_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flick;
    logic [15:0] lamp1, lamp4;
    logic [4:0]  count1, count4;
    logic        busy1, busy4;

    int n_vectors     = 0;
    int n_miscompares = 0;

    // Segment table of the light show: direction, end value, following segment.
    // 0 climb16, 1 fall5, 2 climb11, 3 fall0, 4 climb6, 5 final fall0, 6 kickback fall0
    int seg_dir  [7] = '{1, -1, 1, -1, 1, -1, -1};
    int seg_end  [7] = '{16, 5, 11, 0, 6, 0, 0};
    int seg_next [7] = '{1, 2, 3, 4, 5, 0, 0};

    int m_divs   [2] = '{1, 4};
    bit m_active [2];
    int m_seg    [2];
    int m_cnt    [2];
    int m_div    [2];

    always #5 clk = ~clk;

    bound_flasher_ctrl #(.STEP_DIV(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .flick (flick),
        .lamp  (lamp1),
        .count (count1),
        .busy  (busy1)
    );

    bound_flasher_ctrl #(.STEP_DIV(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .flick (flick),
        .lamp  (lamp4),
        .count (count4),
        .busy  (busy4)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            m_active[k] = 1'b0;
            m_seg[k]    = 0;
            m_cnt[k]    = 0;
            m_div[k]    = 0;
        end
    endtask

    // One lamp step of the model for instance k.
    task automatic modelStep(input int k, input logic f);
        int nxt;
        if (m_seg[k] == 0 && f && (m_cnt[k] == 6 || m_cnt[k] == 11)) begin
            m_seg[k] = 6;
            m_cnt[k] = m_cnt[k] - 1;
        end else if (m_cnt[k] != seg_end[m_seg[k]]) begin
            m_cnt[k] = m_cnt[k] + seg_dir[m_seg[k]];
        end else if (m_seg[k] == 5) begin
            m_active[k] = 1'b0;
            m_cnt[k]    = 0;
        end else begin
            nxt = seg_next[m_seg[k]];
            if (m_seg[k] == 2 && f) nxt = 1;
            m_seg[k] = nxt;
            m_cnt[k] = m_cnt[k] + seg_dir[nxt];
        end
    endtask

    task automatic modelEdge(input logic f);
        for (int k = 0; k < 2; k++) begin
            if (!m_active[k]) begin
                if (f) begin
                    m_active[k] = 1'b1;
                    m_seg[k]    = 0;
                    m_cnt[k]    = 1;
                    m_div[k]    = 0;
                end else begin
                    m_cnt[k] = 0;
                end
            end else begin
                m_div[k]++;
                if (m_div[k] == m_divs[k]) begin
                    m_div[k] = 0;
                    modelStep(k, f);
                end
            end
        end
    endtask

    task automatic checkAll(input string where);
        logic [15:0] lamp_a;
        logic [4:0]  cnt_a;
        logic        busy_a;
        logic [31:0] lamp_e;
        for (int k = 0; k < 2; k++) begin
            lamp_a = (k == 0) ? lamp1 : lamp4;
            cnt_a  = (k == 0) ? count1 : count4;
            busy_a = (k == 0) ? busy1 : busy4;
            lamp_e = ((32'd1 << m_cnt[k]) - 32'd1) & 32'h0000_FFFF;
            checkOutput($sformatf("%s count div%0d", where, m_divs[k]), {27'b0, cnt_a}, m_cnt[k]);
            checkOutput($sformatf("%s lamp div%0d", where, m_divs[k]), {16'b0, lamp_a}, lamp_e);
            checkOutput($sformatf("%s busy div%0d", where, m_divs[k]), {31'b0, busy_a}, {31'b0, m_active[k]});
        end
    endtask

    // Called at a falling edge: drive flick, take one rising edge, check at the next falling edge.
    task automatic applyStimulus(input logic f);
        flick = f;
        @(posedge clk);
        modelEdge(f);
        @(negedge clk);
        checkAll("cyc");
    endtask

    // Called at a falling edge: reset must clear outputs before any clock edge.
    task automatic applyReset();
        rst_n = 1'b0;
        #1;
        modelReset();
        checkAll("async_rst");
        @(posedge clk);
        @(negedge clk);
        checkAll("held_rst");
        rst_n = 1'b1;
    endtask

    initial begin
        int e;
        int mode;
        logic f;
        rst_n = 1'b0;
        flick = 1'b0;
        modelReset();
        #1;
        checkAll("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Single pulse, full show with fixed landmarks; divided instance checked early on.
        applyStimulus(1'b1);
        checkOutput("pulse count div1", {27'b0, count1}, 32'd1);
        checkOutput("pulse count div4", {27'b0, count4}, 32'd1);
        for (e = 1; e <= 60; e++) begin
            applyStimulus(1'b0);
            case (e)
                4:  checkOutput("div4 e4 count", {27'b0, count4}, 32'd2);
                8:  checkOutput("div4 e8 lamp", {16'b0, lamp4}, 32'h0007);
                15: checkOutput("e15 count", {27'b0, count1}, 32'd16);
                26: checkOutput("e26 count", {27'b0, count1}, 32'd5);
                32: checkOutput("e32 count", {27'b0, count1}, 32'd11);
                43: checkOutput("e43 count", {27'b0, count1}, 32'd0);
                49: checkOutput("e49 count", {27'b0, count1}, 32'd6);
                55: checkOutput("e55 count", {27'b0, count1}, 32'd0);
                56: checkOutput("e56 busy", {31'b0, busy1}, 32'd0);
                default: ;
            endcase
        end

        // Mid-sequence reset at climb count 9, then restart.
        applyReset();
        applyStimulus(1'b1);
        e = 0;
        while (!(m_seg[0] == 0 && m_cnt[0] == 9) && e < 40) begin
            applyStimulus(1'b0);
            e++;
        end
        checkOutput("reach count9", {31'b0, (count1 == 5'd9)}, 32'd1);
        applyReset();
        applyStimulus(1'b1);
        checkOutput("restart count", {27'b0, count1}, 32'd1);

        // Randomized phases of differing flick density, with occasional resets.
        for (int r = 0; r < 20; r++) begin
            mode = $urandom_range(0, 3);
            for (int c = 0; c < 150; c++) begin
                case (mode)
                    0:       f = $urandom_range(0, 1) == 1;
                    1:       f = $urandom_range(0, 9) == 0;
                    2:       f = 1'b1;
                    default: f = (c == 0);
                endcase
                applyStimulus(f);
            end
            if (r % 5 == 4) applyReset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
